// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV control FSM: state codes, opcodes,
// ALU source/op selects and a helper that flags the memory-wait states.
package mc_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_FETCH    = 4'd1;
    localparam state_t ST_DECODE   = 4'd2;
    localparam state_t ST_EXEC_R   = 4'd3;
    localparam state_t ST_R_WB     = 4'd4;
    localparam state_t ST_MEM_ADDR = 4'd5;
    localparam state_t ST_MEM_RD   = 4'd6;
    localparam state_t ST_MEM_WB   = 4'd7;
    localparam state_t ST_MEM_WR   = 4'd8;
    localparam state_t ST_BRANCH   = 4'd9;
    localparam state_t ST_TRAP     = 4'd10;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] SRCB_RS2     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH1 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // States that hold a memory request open and are subject to the timeout
    function automatic logic is_wait_state(input state_t st);
        return (st == ST_FETCH) || (st == ST_MEM_RD) || (st == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state -> control-word decoder. Handshake-dependent gating
// (mem_ready, zero) is applied by the parent.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t     state,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       pc_source
);

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALUOP_ADD;
        pc_source     = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = SRCB_FOUR;
            end
            // PC + (imm<<1) is computed speculatively so BRANCH finds the target in ALUOut
            ST_DECODE: begin
                alu_src_b = SRCB_IMM_SH1;
            end
            ST_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                reg_write = 1'b1;
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_source     = 1'b1;
                pc_write_cond = 1'b1;
            end
            ST_IDLE, ST_TRAP: begin
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle main control FSM: state register, opcode-driven sequencing, memory
// timeout and retire counter. Define ILLEGAL_TRAP_EN to trap on unknown opcodes.
module multicycle_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 7,
    parameter int CNT_W    = 32,
    parameter int MEM_TO   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_en,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic                alu_op1,
    output logic                alu_op0,
    output logic                pc_source,
    output logic                busy,
    output logic                instr_done,
    output logic                mem_timeout,
    output logic [CNT_W-1:0]    instr_count
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic                illegal
`endif
);

    localparam int WAIT_W = (MEM_TO > 1) ? $clog2(MEM_TO) : 1;

    state_t            state;
    state_t            state_next;
    state_t            after_retire;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_hit;
    logic              retire;
    logic              op_r, op_ld, op_sd, op_beq, op_known;
    logic              dec_pc_write, dec_pc_write_cond, dec_ir_write;
    logic [1:0]        dec_alu_op;

    mc_ctrl_outdec u_outdec (
        .state         (state),
        .pc_write      (dec_pc_write),
        .pc_write_cond (dec_pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (dec_ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (dec_alu_op),
        .pc_source     (pc_source)
    );

    assign op_r     = (opcode == OPCODE_W'(OP_R));
    assign op_ld    = (opcode == OPCODE_W'(OP_LD));
    assign op_sd    = (opcode == OPCODE_W'(OP_SD));
    assign op_beq   = (opcode == OPCODE_W'(OP_BEQ));
    assign op_known = op_r | op_ld | op_sd | op_beq;

    assign after_retire = run ? ST_FETCH : ST_IDLE;

    // A ready response on the terminal wait cycle takes priority over the abort
    always_comb begin
        timeout_hit = 1'b0;
        if ((MEM_TO != 0) && is_wait_state(state) && !mem_ready &&
            (wait_cnt == WAIT_W'(MEM_TO - 1)))
            timeout_hit = 1'b1;
    end

    always_comb begin
        retire = 1'b0;
        case (state)
            ST_R_WB, ST_MEM_WB, ST_BRANCH: retire = 1'b1;
            ST_MEM_WR:                     retire = mem_ready;
`ifdef ILLEGAL_TRAP_EN
            ST_DECODE:                     retire = 1'b0;
`else
            ST_DECODE:                     retire = !op_known;
`endif
            default:                       retire = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (run) state_next = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready)        state_next = ST_DECODE;
                else if (timeout_hit) state_next = ST_IDLE;
            end
            ST_DECODE: begin
                if (op_r)                state_next = ST_EXEC_R;
                else if (op_ld || op_sd) state_next = ST_MEM_ADDR;
                else if (op_beq)         state_next = ST_BRANCH;
`ifdef ILLEGAL_TRAP_EN
                else                     state_next = ST_TRAP;
`else
                else                     state_next = after_retire;
`endif
            end
            ST_EXEC_R:   state_next = ST_R_WB;
            ST_MEM_ADDR: state_next = op_ld ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                if (mem_ready)        state_next = ST_MEM_WB;
                else if (timeout_hit) state_next = ST_IDLE;
            end
            ST_MEM_WR: begin
                if (mem_ready)        state_next = after_retire;
                else if (timeout_hit) state_next = ST_IDLE;
            end
            ST_R_WB, ST_MEM_WB, ST_BRANCH: state_next = after_retire;
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP:     state_next = ST_TRAP;
`endif
            default:     state_next = ST_IDLE;
        endcase
    end

    // The wait counter restarts on every state change, so each wait state sees a fresh budget
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            instr_count <= '0;
        end else begin
            state <= state_next;
            if (state_next != state)
                wait_cnt <= '0;
            else if ((MEM_TO != 0) && is_wait_state(state) && !mem_ready)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    assign pc_en       = (dec_pc_write & mem_ready) | (dec_pc_write_cond & zero);
    assign ir_write    = dec_ir_write & mem_ready;
    assign alu_op1     = dec_alu_op[1];
    assign alu_op0     = dec_alu_op[0];
    assign busy        = (state != ST_IDLE);
    assign instr_done  = retire;
    assign mem_timeout = timeout_hit;
`ifdef ILLEGAL_TRAP_EN
    assign illegal     = (state == ST_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Table-driven, scoreboarded bench for multicycle_ctrl_fsm (MEM_TO=4); follows the
// ILLEGAL_TRAP_EN define to pick the trap or NOP expectations.
module tb_multicycle_ctrl_fsm;

    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC_R = 3, S_R_WB = 4;
    localparam int S_MEM_ADDR = 5, S_MEM_RD = 6, S_MEM_WB = 7, S_MEM_WR = 8;
    localparam int S_BRANCH = 9, S_TRAP = 10;

    localparam logic [6:0] OPR   = 7'b0110011;
    localparam logic [6:0] OPLD  = 7'b0000011;
    localparam logic [6:0] OPSD  = 7'b0100011;
    localparam logic [6:0] OPBEQ = 7'b1100011;
    localparam logic [6:0] OPBAD = 7'b1111111;

    typedef struct {
        logic        run;
        logic [6:0]  opcode;
        logic        zero;
        logic        ready;
        int          st;
        logic        done;
        logic        tmo;
        int unsigned cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_write;
    logic        alu_src_a, alu_op1, alu_op0, pc_source, busy, instr_done, mem_timeout;
    logic [1:0]  alu_src_b;
    logic [31:0] instr_count;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    int   tests = 0;
    int   fails = 0;
    vec_t vecs[$];
    vec_t seq[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.OPCODE_W(7), .CNT_W(32), .MEM_TO(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_en       (pc_en),
        .iord        (iord),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op1     (alu_op1),
        .alu_op0     (alu_op0),
        .pc_source   (pc_source),
        .busy        (busy),
        .instr_done  (instr_done),
        .mem_timeout (mem_timeout),
        .instr_count (instr_count)
`ifdef ILLEGAL_TRAP_EN
        ,
        .illegal     (illegal)
`endif
    );

    function automatic vec_t mk(logic r, logic [6:0] op, logic z, logic rdy, int st,
                                logic done, logic tmo, int unsigned cnt);
        vec_t v;
        v.run = r; v.opcode = op; v.zero = z; v.ready = rdy;
        v.st = st; v.done = done; v.tmo = tmo; v.cnt = cnt;
        return v;
    endfunction

    // {iord, mem_read, mem_write, mem_to_reg, reg_write, src_a, src_b, op1, op0, pc_source, busy}
    function automatic logic [11:0] moore_word(int st);
        case (st)
            S_FETCH:    return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1};
            S_DECODE:   return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1};
            S_EXEC_R:   return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1};
            S_R_WB:     return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
            S_MEM_ADDR: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1};
            S_MEM_RD:   return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
            S_MEM_WB:   return {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
            S_MEM_WR:   return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
            S_BRANCH:   return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1};
            S_TRAP:     return 12'h001;
            default:    return 12'h000;
        endcase
    endfunction

    function automatic logic [15:0] expected_word(vec_t v);
        logic pce, irw;
        pce = (v.st == S_FETCH && v.ready) || (v.st == S_BRANCH && v.zero);
        irw = (v.st == S_FETCH && v.ready);
        return {pce, irw, moore_word(v.st), v.done, v.tmo};
    endfunction

    function automatic logic [15:0] actual_word();
        return {pc_en, ir_write, iord, mem_read, mem_write, mem_to_reg, reg_write, alu_src_a,
                alu_src_b, alu_op1, alu_op0, pc_source, busy, instr_done, mem_timeout};
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        run       = v.run;
        opcode    = v.opcode;
        zero      = v.zero;
        mem_ready = v.ready;
        exp_q.push_back(v);
    endtask

    task automatic checkOutput(input string name);
        vec_t v;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s: scoreboard empty, got word 0x%0h", name, actual_word());
        end else begin
            v = exp_q.pop_front();
            checkVal({name, " ctrl"}, {16'h0, actual_word()}, {16'h0, expected_word(v)});
            checkVal({name, " count"}, instr_count, v.cnt);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // idle, then R-type
        repeat (5) vecs.push_back(mk(0, OPR, 0, 1, S_IDLE, 0, 0, 0));
        vecs.push_back(mk(1, OPR, 0, 0, S_IDLE,     0, 0, 0));
        vecs.push_back(mk(1, OPR, 0, 1, S_FETCH,    0, 0, 0));
        vecs.push_back(mk(1, OPR, 0, 0, S_DECODE,   0, 0, 0));
        vecs.push_back(mk(0, OPR, 0, 0, S_EXEC_R,   0, 0, 0));
        vecs.push_back(mk(0, OPR, 0, 0, S_R_WB,     1, 0, 0));
        vecs.push_back(mk(0, OPR, 0, 0, S_IDLE,     0, 0, 1));
        // ld with two wait cycles in MEM_RD
        vecs.push_back(mk(1, OPLD, 0, 0, S_IDLE,     0, 0, 1));
        vecs.push_back(mk(1, OPLD, 0, 1, S_FETCH,    0, 0, 1));
        vecs.push_back(mk(1, OPLD, 0, 0, S_DECODE,   0, 0, 1));
        vecs.push_back(mk(1, OPLD, 0, 0, S_MEM_ADDR, 0, 0, 1));
        vecs.push_back(mk(1, OPLD, 0, 0, S_MEM_RD,   0, 0, 1));
        vecs.push_back(mk(1, OPLD, 0, 0, S_MEM_RD,   0, 0, 1));
        vecs.push_back(mk(1, OPLD, 0, 1, S_MEM_RD,   0, 0, 1));
        vecs.push_back(mk(1, OPLD, 0, 0, S_MEM_WB,   1, 0, 1));
        // beq taken then not taken, back to back
        vecs.push_back(mk(1, OPBEQ, 0, 1, S_FETCH,  0, 0, 2));
        vecs.push_back(mk(1, OPBEQ, 1, 0, S_DECODE, 0, 0, 2));
        vecs.push_back(mk(1, OPBEQ, 1, 0, S_BRANCH, 1, 0, 2));
        vecs.push_back(mk(1, OPBEQ, 0, 1, S_FETCH,  0, 0, 3));
        vecs.push_back(mk(0, OPBEQ, 0, 0, S_DECODE, 0, 0, 3));
        vecs.push_back(mk(0, OPBEQ, 0, 0, S_BRANCH, 1, 0, 3));
        vecs.push_back(mk(0, OPBEQ, 0, 0, S_IDLE,   0, 0, 4));
        // sd retiring on mem_ready
        vecs.push_back(mk(1, OPSD, 0, 0, S_IDLE,     0, 0, 4));
        vecs.push_back(mk(1, OPSD, 0, 1, S_FETCH,    0, 0, 4));
        vecs.push_back(mk(1, OPSD, 0, 0, S_DECODE,   0, 0, 4));
        vecs.push_back(mk(1, OPSD, 0, 0, S_MEM_ADDR, 0, 0, 4));
        vecs.push_back(mk(1, OPSD, 0, 0, S_MEM_WR,   0, 0, 4));
        vecs.push_back(mk(0, OPSD, 0, 1, S_MEM_WR,   1, 0, 4));
        vecs.push_back(mk(0, OPSD, 0, 0, S_IDLE,     0, 0, 5));
        // FETCH timeout on the fourth unready cycle
        vecs.push_back(mk(1, OPR, 0, 0, S_IDLE, 0, 0, 5));
        repeat (3) vecs.push_back(mk(0, OPR, 0, 0, S_FETCH, 0, 0, 5));
        vecs.push_back(mk(0, OPR, 0, 0, S_FETCH, 0, 1, 5));
        vecs.push_back(mk(0, OPR, 0, 0, S_IDLE,  0, 0, 5));
        // mem_ready on the terminal wait cycle beats the timeout
        vecs.push_back(mk(1, OPR, 0, 0, S_IDLE, 0, 0, 5));
        repeat (3) vecs.push_back(mk(0, OPR, 0, 0, S_FETCH, 0, 0, 5));
        vecs.push_back(mk(0, OPR, 0, 1, S_FETCH,  0, 0, 5));
        vecs.push_back(mk(0, OPR, 0, 0, S_DECODE, 0, 0, 5));
        vecs.push_back(mk(0, OPR, 0, 0, S_EXEC_R, 0, 0, 5));
        vecs.push_back(mk(0, OPR, 0, 0, S_R_WB,   1, 0, 5));
        vecs.push_back(mk(0, OPR, 0, 0, S_IDLE,   0, 0, 6));
        // MEM_RD timeout: wait budget restarts after FETCH waits
        vecs.push_back(mk(1, OPLD, 0, 0, S_IDLE, 0, 0, 6));
        repeat (2) vecs.push_back(mk(0, OPLD, 0, 0, S_FETCH, 0, 0, 6));
        vecs.push_back(mk(0, OPLD, 0, 1, S_FETCH,    0, 0, 6));
        vecs.push_back(mk(0, OPLD, 0, 0, S_DECODE,   0, 0, 6));
        vecs.push_back(mk(0, OPLD, 0, 0, S_MEM_ADDR, 0, 0, 6));
        repeat (3) vecs.push_back(mk(0, OPLD, 0, 0, S_MEM_RD, 0, 0, 6));
        vecs.push_back(mk(0, OPLD, 0, 0, S_MEM_RD, 0, 1, 6));
        vecs.push_back(mk(0, OPLD, 0, 0, S_IDLE,   0, 0, 6));
        // unknown opcode
        vecs.push_back(mk(1, OPBAD, 0, 0, S_IDLE,  0, 0, 6));
        vecs.push_back(mk(0, OPBAD, 0, 1, S_FETCH, 0, 0, 6));
`ifdef ILLEGAL_TRAP_EN
        vecs.push_back(mk(1, OPBAD, 0, 0, S_DECODE, 0, 0, 6));
        repeat (3) vecs.push_back(mk(1, OPBAD, 0, 1, S_TRAP, 0, 0, 6));
`else
        vecs.push_back(mk(0, OPBAD, 0, 0, S_DECODE, 1, 0, 6));
        vecs.push_back(mk(1, OPBAD, 0, 0, S_IDLE,   0, 0, 7));
`endif

        // R-type retire, then ld interrupted by reset in MEM_RD
        seq.push_back(mk(1, OPR,  0, 0, S_IDLE,     0, 0, 0));
        seq.push_back(mk(1, OPR,  0, 1, S_FETCH,    0, 0, 0));
        seq.push_back(mk(1, OPR,  0, 0, S_DECODE,   0, 0, 0));
        seq.push_back(mk(1, OPR,  0, 0, S_EXEC_R,   0, 0, 0));
        seq.push_back(mk(1, OPR,  0, 0, S_R_WB,     1, 0, 0));
        seq.push_back(mk(1, OPLD, 0, 1, S_FETCH,    0, 0, 1));
        seq.push_back(mk(1, OPLD, 0, 0, S_DECODE,   0, 0, 1));
        seq.push_back(mk(1, OPLD, 0, 0, S_MEM_ADDR, 0, 0, 1));
        seq.push_back(mk(1, OPLD, 0, 0, S_MEM_RD,   0, 0, 1));

        rst_n = 1'b0; run = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVal("reset ctrl", {16'h0, actual_word()}, 32'h0);
        checkVal("reset count", instr_count, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i));
        end

`ifdef ILLEGAL_TRAP_EN
        checkVal("illegal sticky", {31'h0, illegal}, 32'h1);
`endif
        @(negedge clk);
        rst_n = 1'b0; run = 1'b0;
        #1;
        checkVal("reset pulse busy", {31'h0, busy}, 32'h0);
        checkVal("reset pulse count", instr_count, 32'h0);
`ifdef ILLEGAL_TRAP_EN
        checkVal("illegal cleared", {31'h0, illegal}, 32'h0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < seq.size(); i++) begin
            @(posedge clk); #1;
            applyStimulus(seq[i]);
            @(negedge clk);
            checkOutput($sformatf("seq%0d", i));
        end

        // asynchronous reset lands mid-MEM_RD; outputs drop without a clock edge
        rst_n = 1'b0;
        #1;
        checkVal("midrd busy", {31'h0, busy}, 32'h0);
        checkVal("midrd mem_read", {31'h0, mem_read}, 32'h0);
        checkVal("midrd count", instr_count, 32'h0);
        @(posedge clk); #1;
        run = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checkVal("post-reset ctrl", {16'h0, actual_word()}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
